mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data access unit: splits loads/stores into byte-wide RAM transfers,
// stalls the pipeline while they run, and presents the assembled result once.
module mem_access #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           store_data_i,
    input  logic                  hold_i,
    input  logic [7:0]            ram_rdata_i,
    input  logic                  ram_ack_i,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [7:0]            ram_wdata_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [31:0] buf_reg;
    logic [3:0]  op_reg;
    logic [31:0] load_data;
    logic [4:0]  lane_lsb;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Index of the final byte of the op (byte count minus one).
    function automatic logic [1:0] last_cnt(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    assign lane_lsb = {cnt_reg, 3'b000};

    // The op is latched on entry so the DONE formatting does not depend on
    // upstream keeping mem_op_i steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            buf_reg   <= 32'd0;
            op_reg    <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_mem(mem_op_i)) begin
                        state_reg <= BUSY;
                        cnt_reg   <= 2'd0;
                        buf_reg   <= 32'd0;
                        op_reg    <= mem_op_i;
                    end
                end
                BUSY: begin
                    if (ram_ack_i) begin
                        if (!is_store(op_reg)) begin
                            buf_reg[lane_lsb +: 8] <= ram_rdata_i;
                        end
                        if (cnt_reg == last_cnt(op_reg)) begin
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 2'd1;
                        end
                    end
                end
                DONE: begin
                    if (!hold_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (op_reg)
            OP_LB:   load_data = {{24{buf_reg[7]}}, buf_reg[7:0]};
            OP_LBU:  load_data = {24'd0, buf_reg[7:0]};
            OP_LH:   load_data = {{16{buf_reg[15]}}, buf_reg[15:0]};
            OP_LHU:  load_data = {16'd0, buf_reg[15:0]};
            default: load_data = buf_reg;
        endcase
    end

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = mem_addr_i + ADDR_WIDTH'(cnt_reg);
        ram_wdata_o = 8'd0;
        case (state_reg)
            IDLE: begin
                // Stall in the detect cycle itself so the op cannot slip past.
                if (is_mem(mem_op_i)) begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                end
            end
            BUSY: begin
                stallreq_o  = 1'b1;
                wreg_o      = 1'b0;
                ram_req_o   = 1'b1;
                ram_we_o    = is_store(op_reg);
                ram_wdata_o = store_data_i[lane_lsb +: 8];
            end
            DONE: begin
                if (is_store(op_reg)) begin
                    wreg_o = 1'b0;
                end else begin
                    wdata_o = load_data;
                end
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: byte-serial loads/stores, wait states,
// address wrap, reset mid-transfer and DONE hold.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic        hold_i;
    logic [7:0]  ram_rdata_i;
    logic        ram_ack_i;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    mem_access #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .hold_i(hold_i), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op from IDLE to the following IDLE cycle. rbytes holds the
    // RAM bytes little-endian; each byte is acked after wait_n extra cycles.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rbytes, input int n,
                          input int wait_n, input int hold_n, input logic exp_wreg,
                          input logic [31:0] exp_data);
        logic st;
        st = (op >= 4'd6);
        mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        hold_i = 1'b0; ram_ack_i = 1'b0;
        #1;
        chk({name, " detect stall"}, 32'(stallreq_o), 32'd1);
        chk({name, " detect req"},   32'(ram_req_o),  32'd0);
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w <= wait_n; w++) begin
                tick();
                ram_ack_i   = (w == wait_n);
                ram_rdata_i = rbytes[8*i +: 8];
                #1;
                chk({name, " busy req"},  32'(ram_req_o), 32'd1);
                chk({name, " busy addr"}, ram_addr_o, addr + 32'(i));
                chk({name, " busy we"},   32'(ram_we_o), 32'(st));
                if (st) chk({name, " busy wbyte"}, 32'(ram_wdata_o), 32'(sdata[8*i +: 8]));
                chk({name, " busy stall/wreg"}, {30'd0, stallreq_o, wreg_o}, 32'd2);
                $display("  %s byte %0d wait %0d addr=%h ack=%0d", name, i, w, ram_addr_o, ram_ack_i);
            end
        end
        for (int h = 0; h <= hold_n; h++) begin
            tick();
            ram_ack_i = 1'b0;
            hold_i    = (h < hold_n);
            #1;
            chk({name, " done stall/req"}, {30'd0, stallreq_o, ram_req_o}, 32'd0);
            chk({name, " done wreg"}, 32'(wreg_o), 32'(exp_wreg));
            chk({name, " done wd"},   32'(wd_o),   32'd9);
            if (!st) chk({name, " done data"}, wdata_o, exp_data);
        end
        tick();
        mem_op_i = 4'd0; hold_i = 1'b0; wdata_i = 32'h0000_5A5A;
        #1;
        chk({name, " back idle"}, {30'd0, stallreq_o, ram_req_o}, 32'd0);
        chk({name, " idle pass"}, wdata_o, 32'h0000_5A5A);
        $display("%s addr=%h result=%h wreg=%0d", name, addr, exp_data, exp_wreg);
    endtask

    initial begin
        rst = 1'b1; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; mem_op_i = 4'd0;
        mem_addr_i = 32'd0; store_data_i = 32'd0; hold_i = 1'b0;
        ram_rdata_i = 8'd0; ram_ack_i = 1'b0;
        #2;
        chk("reset req",   32'(ram_req_o),  32'd0);
        chk("reset stall", 32'(stallreq_o), 32'd0);
        tick(); tick();
        rst = 1'b0;

        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h0000_1234; #1;
        chk("none wd",    32'(wd_o),   32'd5);
        chk("none wreg",  32'(wreg_o), 32'd1);
        chk("none wdata", wdata_o,     32'h0000_1234);
        chk("none stall/req", {30'd0, stallreq_o, ram_req_o}, 32'd0);
        mem_op_i = 4'd9; #1;
        chk("op9 stall", 32'(stallreq_o), 32'd0);
        chk("op9 wdata", wdata_o, 32'h0000_1234);
        $display("none op passthrough wdata=%h", wdata_o);
        tick();
        mem_op_i = 4'd0;

        run_op("LW",  4'd3, 32'h0000_0100, 32'd0, 32'h1234_5678, 4, 0, 0, 1'b1, 32'h1234_5678);
        run_op("LB",  4'd1, 32'h0000_0040, 32'd0, 32'h0000_0080, 1, 0, 0, 1'b1, 32'hFFFF_FF80);
        run_op("LBU", 4'd4, 32'h0000_0040, 32'd0, 32'h0000_0080, 1, 0, 0, 1'b1, 32'h0000_0080);
        run_op("LH",  4'd2, 32'h0000_0041, 32'd0, 32'h0000_8000, 2, 0, 0, 1'b1, 32'hFFFF_8000);
        run_op("LHU", 4'd5, 32'h0000_0041, 32'd0, 32'h0000_8000, 2, 1, 0, 1'b1, 32'h0000_8000);
        run_op("SH",  4'd7, 32'hFFFF_FFFF, 32'h0000_AABB, 32'd0, 2, 2, 0, 1'b0, 32'd0);
        run_op("SW",  4'd8, 32'h0000_0200, 32'hCAFE_F00D, 32'd0, 4, 0, 0, 1'b0, 32'd0);

        // Reset after the second byte of an LW; the retry must start at byte 0.
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0300; wreg_i = 1'b1;
        tick(); ram_ack_i = 1'b1; ram_rdata_i = 8'h11;
        tick(); ram_rdata_i = 8'h22;
        tick(); ram_ack_i = 1'b0;
        #1;
        chk("rst pre addr", ram_addr_o, 32'h0000_0302);
        #1; rst = 1'b1; #1;
        chk("rst req now", 32'(ram_req_o), 32'd0);
        chk("rst wreg",    32'(wreg_o),    32'd0);
        $display("reset mid-LW req=%0d", ram_req_o);
        tick();
        rst = 1'b0;
        run_op("LW-retry", 4'd3, 32'h0000_0300, 32'd0, 32'hA1B2_C3D4, 4, 0, 0, 1'b1, 32'hA1B2_C3D4);

        run_op("LW-hold", 4'd3, 32'h0000_0010, 32'd0, 32'h0102_0304, 4, 0, 3, 1'b1, 32'h0102_0304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
